// File: rtl/reorder_buffer_multi.sv
// Circular reorder buffer: multi-lane allocate at tail, tag-addressed writeback,
// in-order multi-lane retire from head with a sticky exception stop, and operand reads with wb bypass.
module reorder_buffer_multi #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 5,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_WB         = 2,
   parameter int NUM_RETIRE     = 2,
   parameter int NUM_READ       = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 flush,
   input  logic [NUM_WB-1:0]                    alloc_vld,
   input  logic [NUM_WB-1:0]                    alloc_reg_write,
   input  logic [NUM_WB*REG_ADDR_WIDTH-1:0]     alloc_address,
   output logic                                 alloc_ready,
   output logic [NUM_WB*ADDR_WIDTH-1:0]         alloc_tag,
   input  logic [NUM_WB-1:0]                    wb_vld,
   input  logic [NUM_WB*ADDR_WIDTH-1:0]         wb_tag,
   input  logic [NUM_WB*DATA_WIDTH-1:0]         wb_data,
   input  logic [NUM_WB-1:0]                    wb_exc,
   output logic [NUM_RETIRE-1:0]                retire_vld,
   output logic [NUM_RETIRE*ADDR_WIDTH-1:0]     retire_tag,
   output logic [NUM_RETIRE*DATA_WIDTH-1:0]     retire_data,
   output logic [NUM_RETIRE-1:0]                retire_reg_write,
   output logic [NUM_RETIRE*REG_ADDR_WIDTH-1:0] retire_address,
   output logic                                 exception,
   output logic [ADDR_WIDTH-1:0]                exception_tag,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]       read_tag,
   output logic [NUM_READ*DATA_WIDTH-1:0]       read_data,
   output logic [NUM_READ-1:0]                  read_ready,
   output logic [ADDR_WIDTH:0]                  count,
   output logic                                 empty,
   output logic                                 full
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] NUM_WB_C = CW'(NUM_WB);

   logic [DEPTH-1:0]          ent_alloc, ent_done, ent_exc, ent_reg_write;
   logic [REG_ADDR_WIDTH-1:0] ent_address [DEPTH];
   logic [DATA_WIDTH-1:0]     ent_data    [DEPTH];
   logic [ADDR_WIDTH-1:0]     head, tail;
   logic [CW-1:0]             count_q;
   logic                      exc_q;
   logic [ADDR_WIDTH-1:0]     exc_tag_q;

   logic [ADDR_WIDTH-1:0]     alloc_idx [NUM_WB];
   logic [ADDR_WIDTH-1:0]     wb_idx    [NUM_WB];
   logic [ADDR_WIDTH-1:0]     ret_idx   [NUM_RETIRE];
   logic [ADDR_WIDTH-1:0]     rd_idx    [NUM_READ];
   logic [CW-1:0]             n_alloc, n_retire;
   logic [NUM_RETIRE-1:0]     ret_vld;
   logic                      ret_stop;
   logic                      exc_hit;
   logic [ADDR_WIDTH-1:0]     exc_hit_tag;

   // Same-cycle retires are deliberately not credited to free space.
   assign alloc_ready   = ((DEPTH_C - count_q) >= NUM_WB_C) && !flush;
   assign count         = count_q;
   assign empty         = (count_q == '0);
   assign full          = (count_q == DEPTH_C);
   assign exception     = exc_q;
   assign exception_tag = exc_tag_q;
   assign retire_vld    = ret_vld;

   always_comb begin
      n_alloc   = '0;
      alloc_tag = '0;
      for (int k = 0; k < NUM_WB; k++) begin
         alloc_idx[k] = tail + ADDR_WIDTH'(k);
         wb_idx[k]    = wb_tag[k*ADDR_WIDTH +: ADDR_WIDTH];
         alloc_tag[k*ADDR_WIDTH +: ADDR_WIDTH] = alloc_idx[k];
         if (alloc_ready && alloc_vld[k]) n_alloc = n_alloc + CW'(1);
      end
   end

   // Walk from head; the first entry that is not cleanly done ends the retire group.
   always_comb begin
      ret_vld     = '0;
      n_retire    = '0;
      exc_hit     = 1'b0;
      exc_hit_tag = '0;
      ret_stop    = exc_q;
      for (int k = 0; k < NUM_RETIRE; k++) begin
         ret_idx[k] = head + ADDR_WIDTH'(k);
         if (!ret_stop) begin
            if (CW'(k) >= count_q) begin
               ret_stop = 1'b1;
            end else if (ent_alloc[ret_idx[k]] && ent_done[ret_idx[k]] && !ent_exc[ret_idx[k]]) begin
               ret_vld[k] = 1'b1;
               n_retire   = n_retire + CW'(1);
            end else begin
               if (ent_alloc[ret_idx[k]] && ent_done[ret_idx[k]]) begin
                  exc_hit     = 1'b1;
                  exc_hit_tag = ret_idx[k];
               end
               ret_stop = 1'b1;
            end
         end
      end
   end

   always_comb begin
      retire_tag       = '0;
      retire_data      = '0;
      retire_reg_write = '0;
      retire_address   = '0;
      for (int k = 0; k < NUM_RETIRE; k++) begin
         retire_tag[k*ADDR_WIDTH +: ADDR_WIDTH]         = ret_idx[k];
         retire_data[k*DATA_WIDTH +: DATA_WIDTH]        = ent_data[ret_idx[k]];
         retire_address[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = ent_address[ret_idx[k]];
         retire_reg_write[k] = ret_vld[k] & ent_reg_write[ret_idx[k]];
      end
   end

   // Later wb lanes override earlier ones, so the highest matching lane is forwarded.
   always_comb begin
      read_data  = '0;
      read_ready = '0;
      for (int p = 0; p < NUM_READ; p++) begin
         rd_idx[p] = read_tag[p*ADDR_WIDTH +: ADDR_WIDTH];
         read_data[p*DATA_WIDTH +: DATA_WIDTH] = ent_data[rd_idx[p]];
         read_ready[p] = ent_done[rd_idx[p]] & ent_alloc[rd_idx[p]];
         for (int l = 0; l < NUM_WB; l++) begin
            if (wb_vld[l] && (wb_idx[l] == rd_idx[p])) begin
               read_data[p*DATA_WIDTH +: DATA_WIDTH] = wb_data[l*DATA_WIDTH +: DATA_WIDTH];
               read_ready[p] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_alloc     <= '0;
         ent_done      <= '0;
         ent_exc       <= '0;
         ent_reg_write <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_address[i] <= '0;
            ent_data[i]    <= '0;
         end
         head      <= '0;
         tail      <= '0;
         count_q   <= '0;
         exc_q     <= 1'b0;
         exc_tag_q <= '0;
      end else if (flush) begin
         ent_alloc <= '0;
         ent_done  <= '0;
         ent_exc   <= '0;
         head      <= '0;
         tail      <= '0;
         count_q   <= '0;
         exc_q     <= 1'b0;
         exc_tag_q <= '0;
      end else begin
         // Allocated slots are free and retiring slots are occupied, so these writes never collide.
         for (int k = 0; k < NUM_WB; k++) begin
            if (alloc_ready && alloc_vld[k]) begin
               ent_alloc[alloc_idx[k]]     <= 1'b1;
               ent_done[alloc_idx[k]]      <= 1'b0;
               ent_exc[alloc_idx[k]]       <= 1'b0;
               ent_reg_write[alloc_idx[k]] <= alloc_reg_write[k];
               ent_address[alloc_idx[k]]   <= alloc_address[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            end
         end
         for (int l = 0; l < NUM_WB; l++) begin
            if (wb_vld[l] && ent_alloc[wb_idx[l]]) begin
               ent_done[wb_idx[l]] <= 1'b1;
               ent_exc[wb_idx[l]]  <= wb_exc[l];
               ent_data[wb_idx[l]] <= wb_data[l*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         for (int k = 0; k < NUM_RETIRE; k++) begin
            if (ret_vld[k]) ent_alloc[ret_idx[k]] <= 1'b0;
         end
         head    <= head + n_retire[ADDR_WIDTH-1:0];
         tail    <= tail + n_alloc[ADDR_WIDTH-1:0];
         count_q <= count_q + n_alloc - n_retire;
         if (exc_hit) begin
            exc_q     <= 1'b1;
            exc_tag_q <= exc_hit_tag;
         end
      end
   end

endmodule
